// File: rtl/prio_scan_pkg.sv
// Shared types and helpers for the priority scan encoder.
// Holds the FSM state encoding plus clog2/popcount used to size and drive the datapath.
package prio_scan_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Callers zero-extend their vector to 256 bits, the widest legal WIDTH.
  function automatic logic [8:0] popcount(input logic [255:0] v);
    logic [8:0] c;
    c = '0;
    for (int i = 0; i < 256; i++) c = c + 9'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/prio_find.sv
// Combinational highest- or lowest-set-bit finder.
// LSB_FIRST selects the search direction; any flags a nonzero vector.
module prio_find
  import prio_scan_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0,
  localparam int IDX_W    = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // The last matching iteration wins, so the loop direction sets the priority.
  always_comb begin
    idx = '0;
    any = 1'b0;
    if (LSB_FIRST) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (vec[i]) begin
          idx = IDX_W'(i);
          any = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (vec[i]) begin
          idx = IDX_W'(i);
          any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prio_scan_encoder.sv
// Serialises the set bits of a request vector into one index per beat.
// Define PRIO_SCAN_LSB_FIRST_EN to scan lowest bit first; default is highest bit first.
module prio_scan_encoder
  import prio_scan_pkg::*;
#(
  parameter int WIDTH  = 8,
  localparam int IDX_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic [IDX_W:0]   pending
);

`ifdef PRIO_SCAN_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] vec_q, vec_d;
  logic [IDX_W-1:0] find_idx;
  logic             find_any;
  logic             in_fire, out_fire;

  prio_find #(
    .WIDTH    (WIDTH),
    .LSB_FIRST(LSB_FIRST)
  ) u_find (
    .vec(vec_q),
    .idx(find_idx),
    .any(find_any)
  );

  // Outputs are forced to zero outside SCAN so idle beats look clean downstream.
  always_comb begin
    out_valid = (state_q == SCAN) && find_any;
    out_idx   = out_valid ? find_idx : '0;
    out_last  = out_valid && (popcount(256'(vec_q)) == 9'd1);
    pending   = out_valid ? (IDX_W + 1)'(popcount(256'(vec_q))) : '0;
    out_fire  = out_valid && out_ready;
    in_ready  = (state_q == IDLE) || (out_fire && out_last);
    in_fire   = in_valid && in_ready;
  end

  // A zero vector is accepted but never enters SCAN; a load on the last beat avoids a bubble.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    case (state_q)
      IDLE: begin
        if (in_fire && (|in_vec)) begin
          state_d = SCAN;
          vec_d   = in_vec;
        end
      end
      SCAN: begin
        if (out_fire) begin
          if (out_last) begin
            if (in_fire && (|in_vec)) begin
              vec_d = in_vec;
            end else begin
              state_d = IDLE;
              vec_d   = '0;
            end
          end else begin
            vec_d[find_idx] = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        vec_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
    end
  end

endmodule

// File: tb/tb_prio_scan_encoder.sv
// Scoreboard bench for prio_scan_encoder: directed cases then random traffic.
// Expected beats come from a list-based model of the vector's set bits.
module tb_prio_scan_encoder;

  localparam int W     = 8;
  localparam int IDX_W = 3;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic [IDX_W:0]   pending;

  typedef struct {
    int idx;
    int last;
    int pend;
  } beat_t;

  beat_t exp_q[$];
  int    checks;
  int    errors;
  bit    running;

  prio_scan_encoder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_vec   (in_vec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_idx  (out_idx),
    .out_last (out_last),
    .pending  (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: a vector is just its list of set positions in scan order.
  function automatic void pushBeats(input logic [W-1:0] v);
    int pos[$];
`ifdef PRIO_SCAN_LSB_FIRST_EN
    for (int i = 0; i < W; i++) if (v[i]) pos.push_back(i);
`else
    for (int i = W - 1; i >= 0; i--) if (v[i]) pos.push_back(i);
`endif
    for (int k = 0; k < pos.size(); k++) begin
      beat_t b;
      b.idx  = pos[k];
      b.last = (k == pos.size() - 1) ? 1 : 0;
      b.pend = pos.size() - k;
      exp_q.push_back(b);
    end
  endfunction

  task automatic applyStimulus(input bit v, input logic [W-1:0] vec, input bit rdy);
    bit accept;
    @(posedge clk);
    #1;
    in_valid  = v;
    in_vec    = vec;
    out_ready = rdy;
    accept = v && ((exp_q.size() == 0) || (rdy && exp_q[0].last == 1));
    @(negedge clk);
    #1;
    if (accept) pushBeats(vec);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: compare every cycle against the head of the expected queue.
  always @(negedge clk) begin
    if (running && !rst) begin
      bit ev, er;
      ev = exp_q.size() > 0;
      er = !ev || (out_ready && exp_q[0].last == 1);
      checkOutput("out_valid", int'(out_valid), int'(ev));
      checkOutput("in_ready", int'(in_ready), int'(er));
      if (out_valid && ev) begin
        checkOutput("out_idx", int'(out_idx), exp_q[0].idx);
        checkOutput("out_last", int'(out_last), exp_q[0].last);
        checkOutput("pending", int'(pending), exp_q[0].pend);
        if (out_ready) void'(exp_q.pop_front());
      end else if (!out_valid) begin
        checkOutput("idle_idx", int'(out_idx), 0);
        checkOutput("idle_last", int'(out_last), 0);
        checkOutput("idle_pending", int'(pending), 0);
      end
    end
  end

  initial begin
    checks    = 0;
    errors    = 0;
    running   = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst     = 1'b0;
    running = 1'b1;

    // Descending scan at full throughput.
    applyStimulus(1'b1, 8'b1010_0100, 1'b1);
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b1);

    // Back-pressure holds the first beat stable.
    applyStimulus(1'b1, 8'h81, 1'b0);
    repeat (3) applyStimulus(1'b0, 8'h3C, 1'b0);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b1);

    // Zero vector is swallowed.
    applyStimulus(1'b1, 8'h00, 1'b1);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b1);

    // New vector loaded on the last beat with no bubble.
    applyStimulus(1'b1, 8'h01, 1'b1);
    applyStimulus(1'b1, 8'h10, 1'b1);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b1);

    // Reset mid-scan aborts the vector.
    applyStimulus(1'b1, 8'hFF, 1'b1);
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b1);
    doReset();
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] rv;
      rv = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
      applyStimulus(1'($urandom_range(0, 1)), rv, $urandom_range(0, 3) != 0);
      if (i % 150 == 75) doReset();
    end

    // Drain with a bounded budget.
    for (int i = 0; i < 64 && exp_q.size() > 0; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("drain", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    running = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prio_scan_encoder.md
PRIO_SCAN_ENCODER -- requirements
Module: prio_scan_encoder

Interface
REQ-001 Parameter SHALL be WIDTH, default 8, which is the input vector width (legal range 1..256).
REQ-002 Derived localparam SHALL be IDX_W = max(1, clog2(WIDTH)), the index width; it SHALL NOT be overridable.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on the rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 in_valid  input  1  SHALL indicate that in_vec is offered.
REQ-006 in_ready  output  1  SHALL indicate that the block accepts in_vec this cycle.
REQ-007 in_vec  input  WIDTH  SHALL be the request vector to encode.
REQ-008 out_valid  output  1  SHALL indicate that out_idx is valid.
REQ-009 out_ready  input  1  SHALL indicate that the consumer takes out_idx this cycle.
REQ-010 out_idx  output  IDX_W  SHALL be the index of the current highest-priority set bit.
REQ-011 out_last  output  1  SHALL indicate that the current beat is the final set bit of the vector.
REQ-012 pending  output  IDX_W+1  SHALL be the count of set bits not yet accepted, including the current beat.

Function
REQ-013 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-014 FSM SHALL have two states, IDLE and SCAN; a working register vec_q (WIDTH bits) SHALL hold the remaining bits.
REQ-015 In IDLE, in_ready=1 and out_valid=0.
REQ-016 IDLE + input transfer with nonzero in_vec: vec_q <= in_vec and state -> SCAN; out_valid SHALL rise the following cycle (1-cycle latency).
REQ-017 IDLE + input transfer with in_vec==0: the vector SHALL be accepted and discarded, state stays IDLE, and no output beat is produced.
REQ-018 In SCAN, out_valid=1 and out_idx = position of the highest set bit of vec_q, MSB first by default.
REQ-019 In SCAN, out_last=1 iff popcount(vec_q)==1, and pending=popcount(vec_q).
REQ-020 SCAN + output transfer with out_last=0: that bit SHALL be cleared in vec_q and state stays SCAN, giving one index per cycle at full throughput.
REQ-021 SCAN + output transfer with out_last=1: state -> IDLE and vec_q <= 0.
REQ-022 in_ready SHALL equal (state==IDLE) || (out_valid && out_ready && out_last), a combinational path from out_ready.
REQ-023 If the last beat transfers in the same cycle as a nonzero input transfer, the block SHALL load in_vec and stay in SCAN with no bubble; a zero in_vec in that cycle SHALL send the block to IDLE.
REQ-024 While out_valid && !out_ready, out_idx, out_last and pending SHALL hold stable.
REQ-025 When out_valid=0, out_idx=0, out_last=0 and pending=0.
REQ-026 in_vec SHALL be sampled only on an input transfer; changes at other times SHALL have no effect.

Reset
REQ-027 On rst=1 at a clock edge: state=IDLE and vec_q=0, so out_valid=0, out_idx=0, out_last=0 and pending=0 from the next cycle.
REQ-028 Reset mid-scan SHALL abort the vector and emit no further beats; rst SHALL take precedence over any simultaneous transfer.
REQ-029 in_ready SHALL be 1 in the cycle after reset is released.

Configuration
REQ-030 The macro PRIO_SCAN_LSB_FIRST_EN SHALL control scan order: when defined, priority is lowest set bit first (ascending indices); when undefined, highest set bit first (descending).
REQ-031 The macro SHALL affect only the bit-select order; the ports, latency, out_last and pending SHALL be identical in both builds.

Structure
REQ-032 Shared package prio_scan_pkg SHALL hold the state encodings (IDLE=0, SCAN=1) and the clog2 and popcount helper functions.
REQ-033 The highest-/lowest-set-bit search SHALL be a combinational sub-module prio_find with parameters WIDTH and LSB_FIRST, outputs idx and any; it is instantiated once.
REQ-034 The top level SHALL contain only the FSM, vec_q, and the handshake logic.

Verification (WIDTH=8 unless stated)
REQ-035 Load 8'b1010_0100 with out_ready=1 -> out_idx 7,5,2 on consecutive cycles; pending 3,2,1; out_last only on idx 2.
REQ-036 Load 8'h81, hold out_ready=0 for 3 cycles -> idx 7 stable with pending=2; then with ready high, 7 then 0 with out_last.
REQ-037 Load 8'h00 -> in_ready stays 1, out_valid never asserts, state stays IDLE.
REQ-038 During the last beat of 8'h01, present 8'h10 in the same cycle -> next cycle out_idx=4 with out_valid=1 and no idle cycle.
REQ-039 Load 8'hFF, accept 2 beats, assert rst for 1 cycle -> next cycle out_valid=0, pending=0, in_ready=1.
REQ-040 With PRIO_SCAN_LSB_FIRST_EN defined, load 8'b1010_0100 -> out_idx 2,5,7; with WIDTH=1, load 1'b1 -> out_idx=0 with out_last=1.
